pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter REG_AW, default 5, register-index width.
REQ-003 SHALL have parameter NUM_PROD, default 2, producer stages checked; index 0 is the stage nearest ID (EX), then MEM, and so on.
REQ-004 SHALL have parameter FLUSH_CYC, default 1, range 1..15, cycles IF/ID clear is held after a redirect.
REQ-005 SHALL have parameter STALL_TMO, default 255, stall-cycle limit before timeout error.
REQ-006 SHALL have parameter CNT_W, default 16, performance counter width.
REQ-007 SHALL have ports: clk_in  in  1  clock, rising edge; rst_in  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports: rdy_in  in  1  global enable; if_valid/id_valid/ex_valid  in  1 each  stage occupied.
REQ-009 SHALL have ports: if_pc, id_pc  in  XLEN  PC held in stage; ex_npc  in  XLEN  resolved next PC of EX instruction.
REQ-010 SHALL have ports: id_rs1, id_rs2  in  REG_AW; id_use_rs1, id_use_rs2  in  1  operand actually read.
REQ-011 SHALL have ports: prod_valid  in  NUM_PROD; prod_rd  in  NUM_PROD*REG_AW (slot i at [i*REG_AW +: REG_AW]); prod_is_load  in  NUM_PROD.
REQ-012 SHALL have ports: stall_if_id  out  1  hold IF and IF/ID latch; bubble_id_ex  out  1  insert bubble into ID/EX.
REQ-013 SHALL have ports: if_clear, id_clear  out  1  squash stage contents; redirect_valid  out  1  one-cycle PC load; redirect_pc  out  XLEN.
REQ-014 SHALL have ports: stall_cnt, flush_cnt  out  CNT_W; err_tmo  out  1  sticky timeout flag.

Function
REQ-015 All outputs SHALL be registered; decisions on inputs sampled at edge N appear after edge N.
REQ-016 Mispredict SHALL be: ex_valid && ((id_valid && id_pc != ex_npc) || (!id_valid && if_valid && if_pc != ex_npc)).
REQ-017 Producer i SHALL match when prod_valid[i] && rd_i != 0 && ((id_use_rs1 && rd_i == id_rs1) || (id_use_rs2 && rd_i == id_rs2)); x0 never matches.
REQ-018 Data hazard SHALL be id_valid && (qualifying match) per REQ-027.
REQ-019 FSM states SHALL be RUN, STALL, FLUSH; reset state RUN.
REQ-020 RUN/STALL: mispredict -> FLUSH; else hazard -> STALL; else -> RUN. Mispredict SHALL take priority over hazard in every state.
REQ-021 FLUSH entry edge SHALL set redirect_valid=1 for exactly one cycle with redirect_pc=ex_npc, and if_clear=id_clear=1 for FLUSH_CYC cycles; in FLUSH, hazards SHALL be ignored and a new mispredict SHALL restart FLUSH with a new redirect; at count expiry -> RUN.
REQ-022 In STALL, stall_if_id=bubble_id_ex=1; in RUN and FLUSH both SHALL be 0.
REQ-023 stall_cnt SHALL increment once per cycle spent in STALL; flush_cnt once per FLUSH entry; both wrap modulo 2^CNT_W.
REQ-024 A stall-run counter SHALL count consecutive STALL cycles, clear on leaving STALL, and set err_tmo when it reaches STALL_TMO; err_tmo SHALL stay set until reset and SHALL NOT alter stall behaviour.
REQ-025 With rdy_in=0 all state, counters and outputs SHALL hold; redirect_valid SHALL not re-pulse on resume.

Reset
REQ-026 rst_in low SHALL immediately force RUN and all outputs, counters and err_tmo to 0, including mid-STALL and mid-FLUSH; first decision at the first rising edge after release.

Configuration
REQ-027 Macro HAZARD_FWD_EN: defined -> only producer 0 with prod_is_load[0]=1 can raise a hazard (load-use; forwarding covers the rest); undefined -> any matching producer 0..NUM_PROD-1 raises a hazard.

Structure
REQ-028 State encoding, REQ-004..006 default constants and the rd-match width SHALL live in the shared constant header with the existing bus macros.
REQ-029 The per-producer compare SHALL be a sub-module hazard_match (one instance per producer via generate); all sequential logic stays in pipe_hazard_ctrl.

Verification
REQ-030 Undefined macro, NUM_PROD=2: prod_valid=2'b10, MEM rd=5 == id_rs2=5, id_use_rs2=1 for 3 cycles -> stall_if_id=1 for 3 cycles, stall_cnt=3.
REQ-031 Defined macro: EX rd=7 non-load == id_rs1 -> no stall; same with prod_is_load[0]=1 -> 1 stall cycle.
REQ-032 rd=0 == id_rs1=0 with prod_valid=1 -> no stall in both builds.
REQ-033 FLUSH_CYC=2: id_pc=0x100, ex_npc=0x200, ex_valid=1 while a hazard is also present -> redirect_valid one cycle with 0x200, clears 2 cycles, no stall, flush_cnt=1.
REQ-034 STALL_TMO=4, hazard held 6 cycles -> err_tmo rises after 4th stall cycle, stays 1 after hazard clears; CNT_W=4, 17 stall cycles -> stall_cnt=1.
REQ-035 rst_in low mid-FLUSH -> all outputs 0 asynchronously; rdy_in=0 for 5 cycles mid-STALL -> outputs and counters frozen.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller:
// FSM state encoding, parameter defaults, match and counter widths.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int FLUSH_CYC_DEF = 1;
    localparam int STALL_TMO_DEF = 255;
    localparam int CNT_W_DEF     = 16;

    // Register-index width used by the rd/rs compare.
    localparam int REG_AW_DEF    = 5;

    // FLUSH_CYC is limited to 1..15, so 4 bits hold the countdown.
    localparam int FCNT_W        = 4;

endpackage

// File: rtl/pipe_hazard_match.sv
// hazard_match: compares one producer's rd against the ID operands.
// Ports: i_valid, i_rd, i_rs1, i_rs2, i_use_rs1, i_use_rs2 -> o_match.
module hazard_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_use_rs1,
    input  logic              i_use_rs2,
    output logic              o_match
);

    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = i_use_rs1 && (i_rd == i_rs1);
    assign w_hit2 = i_use_rs2 && (i_rd == i_rs2);

    // x0 is hardwired zero, so writes to it never create a dependency.
    assign o_match = i_valid && (i_rd != '0) && (w_hit1 || w_hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall / flush / redirect control for an in-order pipe.
// In : clk_in, rst_in (async low), rdy_in, stage valids, PCs, ID operands,
//      producer valid/rd/is_load per stage (0 = EX, 1 = MEM, ...).
// Out: stall_if_id, bubble_id_ex, if_clear, id_clear, redirect_valid/pc,
//      stall_cnt, flush_cnt, err_tmo; all registered.
// Macro HAZARD_FWD_EN: only an EX load raises a hazard (forwarding path).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int NUM_PROD  = 2,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int STALL_TMO = STALL_TMO_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       if_valid,
    input  logic                       id_valid,
    input  logic                       ex_valid,
    input  logic [XLEN-1:0]            if_pc,
    input  logic [XLEN-1:0]            id_pc,
    input  logic [XLEN-1:0]            ex_npc,
    input  logic [REG_AW-1:0]          id_rs1,
    input  logic [REG_AW-1:0]          id_rs2,
    input  logic                       id_use_rs1,
    input  logic                       id_use_rs2,
    input  logic [NUM_PROD-1:0]        prod_valid,
    input  logic [NUM_PROD*REG_AW-1:0] prod_rd,
    input  logic [NUM_PROD-1:0]        prod_is_load,
    output logic                       stall_if_id,
    output logic                       bubble_id_ex,
    output logic                       if_clear,
    output logic                       id_clear,
    output logic                       redirect_valid,
    output logic [XLEN-1:0]            redirect_pc,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt,
    output logic                       err_tmo
);

    localparam int TMO_W = (STALL_TMO < 2) ? 1 : $clog2(STALL_TMO + 1);
    localparam logic [TMO_W-1:0]  TMO_LIM = TMO_W'(STALL_TMO);
    localparam logic [FCNT_W-1:0] FC_LOAD = FCNT_W'(FLUSH_CYC - 1);

    logic [1:0]        r_state;
    logic [FCNT_W-1:0] r_fcnt;
    logic [TMO_W-1:0]  r_run;
    logic              r_stall;
    logic              r_clr;
    logic              r_redir;
    logic [XLEN-1:0]   r_redir_pc;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_err;

    logic [NUM_PROD-1:0] w_match;
    logic                w_qual;
    logic                w_hazard;
    logic                w_mispred;
    logic [TMO_W-1:0]    w_run_nxt;
    logic                w_unused;

    for (genvar g = 0; g < NUM_PROD; g++) begin : g_match
        hazard_match #(
            .REG_AW    (REG_AW)
        ) u_match (
            .i_valid   (prod_valid[g]),
            .i_rd      (prod_rd[g*REG_AW +: REG_AW]),
            .i_rs1     (id_rs1),
            .i_rs2     (id_rs2),
            .i_use_rs1 (id_use_rs1),
            .i_use_rs2 (id_use_rs2),
            .o_match   (w_match[g])
        );
    end

`ifdef HAZARD_FWD_EN
    // Forwarding resolves everything except a load still in EX.
    assign w_qual = w_match[0] & prod_is_load[0];
`else
    assign w_qual = |w_match;
`endif

    // Some producer flags feed only one of the two builds.
    assign w_unused = ^{prod_is_load, w_match};

    assign w_hazard  = id_valid && w_qual;

    // Compare against the oldest younger instruction actually present.
    assign w_mispred = ex_valid &&
                       ((id_valid && (id_pc != ex_npc)) ||
                        (!id_valid && if_valid && (if_pc != ex_npc)));

    // Run length saturates so a very long stall cannot wrap it.
    assign w_run_nxt = (r_run == TMO_LIM) ? r_run : r_run + 1'b1;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ST_RUN;
            r_fcnt      <= '0;
            r_run       <= '0;
            r_stall     <= 1'b0;
            r_clr       <= 1'b0;
            r_redir     <= 1'b0;
            r_redir_pc  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_err       <= 1'b0;
        end else if (rdy_in) begin
            if (w_mispred) begin
                r_state     <= ST_FLUSH;
                r_fcnt      <= FC_LOAD;
                r_run       <= '0;
                r_stall     <= 1'b0;
                r_clr       <= 1'b1;
                r_redir     <= 1'b1;
                r_redir_pc  <= ex_npc;
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end else if (r_state == ST_FLUSH) begin
                r_redir <= 1'b0;
                if (r_fcnt == '0) begin
                    r_state <= ST_RUN;
                    r_clr   <= 1'b0;
                end else begin
                    r_fcnt  <= r_fcnt - 1'b1;
                end
            end else if (w_hazard) begin
                r_state     <= ST_STALL;
                r_stall     <= 1'b1;
                r_stall_cnt <= r_stall_cnt + 1'b1;
                r_run       <= w_run_nxt;
                if (w_run_nxt == TMO_LIM) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_state <= ST_RUN;
                r_stall <= 1'b0;
                r_run   <= '0;
            end
        end
    end

    assign stall_if_id    = r_stall;
    assign bubble_id_ex   = r_stall;
    assign if_clear       = r_clr;
    assign id_clear       = r_clr;
    assign redirect_valid = r_redir;
    assign redirect_pc    = r_redir_pc;
    assign stall_cnt      = r_stall_cnt;
    assign flush_cnt      = r_flush_cnt;
    assign err_tmo        = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYC=2, STALL_TMO=4, CNT_W=4).
// Expectations adapt to whether HAZARD_FWD_EN is defined.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_valid;
    logic        id_valid;
    logic        ex_valid;
    logic [31:0] if_pc;
    logic [31:0] id_pc;
    logic [31:0] ex_npc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [1:0]  prod_valid;
    logic [9:0]  prod_rd;
    logic [1:0]  prod_is_load;
    logic        stall_if_id;
    logic        bubble_id_ex;
    logic        if_clear;
    logic        id_clear;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;
    logic        err_tmo;

    int n_chk = 0;
    int n_fail = 0;

    pipe_hazard_ctrl #(
        .XLEN      (32),
        .REG_AW    (5),
        .NUM_PROD  (2),
        .FLUSH_CYC (2),
        .STALL_TMO (4),
        .CNT_W     (4)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .if_valid       (if_valid),
        .id_valid       (id_valid),
        .ex_valid       (ex_valid),
        .if_pc          (if_pc),
        .id_pc          (id_pc),
        .ex_npc         (ex_npc),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .prod_valid     (prod_valid),
        .prod_rd        (prod_rd),
        .prod_is_load   (prod_is_load),
        .stall_if_id    (stall_if_id),
        .bubble_id_ex   (bubble_id_ex),
        .if_clear       (if_clear),
        .id_clear       (id_clear),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .err_tmo        (err_tmo)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in       = 1'b1;
        if_valid     = 1'b0;
        id_valid     = 1'b0;
        ex_valid     = 1'b0;
        if_pc        = '0;
        id_pc        = '0;
        ex_npc       = '0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        prod_valid   = '0;
        prod_rd      = '0;
        prod_is_load = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
    endtask

    // EX load writing x3, ID reads x3: a hazard in both builds.
    task automatic load_use(input logic on);
        id_valid     = 1'b1;
        id_rs1       = 5'd3;
        id_use_rs1   = 1'b1;
        prod_rd      = {5'd0, 5'd3};
        prod_is_load = 2'b01;
        prod_valid   = on ? 2'b01 : 2'b00;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b0;
        #2;
        n_chk++;
        if ({stall_if_id, bubble_id_ex, if_clear, id_clear,
             redirect_valid, err_tmo} !== 6'b0 ||
            redirect_pc !== 32'd0 || stall_cnt !== 4'd0 ||
            flush_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_out: got st=%b bb=%b clr=%b%b rv=%b pc=%h sc=%0d fc=%0d err=%b expected all 0",
                     stall_if_id, bubble_id_ex, if_clear, id_clear,
                     redirect_valid, redirect_pc, stall_cnt,
                     flush_cnt, err_tmo);
        end
        tick();
        rst_in = 1'b1;
        tick();
        n_chk++;
        if (stall_if_id !== 1'b0 || redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got st=%b rv=%b expected 0 0",
                     stall_if_id, redirect_valid);
        end
    endtask

    task automatic test_mem_hazard();
        logic       e_st;
        logic [3:0] e_cnt;
        e_st  = !FWD;
        e_cnt = FWD ? 4'd0 : 4'd3;
        do_reset();
        id_valid   = 1'b1;
        id_rs2     = 5'd5;
        id_use_rs2 = 1'b1;
        prod_rd    = {5'd5, 5'd0};
        prod_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (stall_if_id !== e_st || bubble_id_ex !== e_st) begin
                n_fail++;
                $display("FAIL mem_stall c%0d: got %b/%b expected %b",
                         i, stall_if_id, bubble_id_ex, e_st);
            end
        end
        prod_valid = 2'b00;
        tick();
        n_chk++;
        if (stall_if_id !== 1'b0 || stall_cnt !== e_cnt) begin
            n_fail++;
            $display("FAIL mem_cnt: got st=%b cnt=%0d expected 0 %0d",
                     stall_if_id, stall_cnt, e_cnt);
        end
    endtask

    task automatic test_load_use();
        logic       e_st;
        logic [3:0] e_cnt;
        e_st  = !FWD;
        e_cnt = FWD ? 4'd1 : 4'd2;
        do_reset();
        id_valid     = 1'b1;
        id_rs1       = 5'd7;
        id_use_rs1   = 1'b1;
        prod_rd      = {5'd0, 5'd7};
        prod_valid   = 2'b01;
        prod_is_load = 2'b00;
        tick();
        n_chk++;
        if (stall_if_id !== e_st) begin
            n_fail++;
            $display("FAIL ex_alu: got %b expected %b", stall_if_id, e_st);
        end
        prod_is_load = 2'b01;
        tick();
        n_chk++;
        if (stall_if_id !== 1'b1) begin
            n_fail++;
            $display("FAIL ex_load: got %b expected 1", stall_if_id);
        end
        prod_valid = 2'b00;
        tick();
        n_chk++;
        if (stall_if_id !== 1'b0 || stall_cnt !== e_cnt) begin
            n_fail++;
            $display("FAIL ld_cnt: got st=%b cnt=%0d expected 0 %0d",
                     stall_if_id, stall_cnt, e_cnt);
        end
    endtask

    task automatic test_x0();
        do_reset();
        id_valid     = 1'b1;
        id_use_rs1   = 1'b1;
        id_use_rs2   = 1'b1;
        prod_valid   = 2'b11;
        prod_is_load = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (stall_if_id !== 1'b0 || stall_cnt !== 4'd0) begin
                n_fail++;
                $display("FAIL x0 c%0d: got st=%b cnt=%0d expected 0 0",
                         i, stall_if_id, stall_cnt);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        load_use(1'b1);
        id_pc    = 32'h100;
        ex_npc   = 32'h200;
        ex_valid = 1'b1;
        tick();
        n_chk++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200 ||
            if_clear !== 1'b1 || id_clear !== 1'b1 ||
            stall_if_id !== 1'b0 || flush_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL flush_entry: got rv=%b pc=%h clr=%b%b st=%b fc=%0d expected 1 200 11 0 1",
                     redirect_valid, redirect_pc, if_clear, id_clear,
                     stall_if_id, flush_cnt);
        end
        ex_valid = 1'b0;
        tick();
        n_chk++;
        if (redirect_valid !== 1'b0 || if_clear !== 1'b1 ||
            id_clear !== 1'b1 || stall_if_id !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_hold: got rv=%b clr=%b%b st=%b expected 0 11 0",
                     redirect_valid, if_clear, id_clear, stall_if_id);
        end
        tick();
        n_chk++;
        if (if_clear !== 1'b0 || id_clear !== 1'b0 ||
            stall_if_id !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_exit: got clr=%b%b st=%b expected 00 0",
                     if_clear, id_clear, stall_if_id);
        end
        tick();
        n_chk++;
        if (stall_if_id !== 1'b1 || stall_cnt !== 4'd1 ||
            flush_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL post_flush: got st=%b sc=%0d fc=%0d expected 1 1 1",
                     stall_if_id, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        id_valid = 1'b1;
        id_pc    = 32'h100;
        ex_npc   = 32'h200;
        ex_valid = 1'b1;
        tick();
        ex_npc = 32'h300;
        tick();
        n_chk++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300 ||
            flush_cnt !== 4'd2 || if_clear !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got rv=%b pc=%h fc=%0d clr=%b expected 1 300 2 1",
                     redirect_valid, redirect_pc, flush_cnt, if_clear);
        end
        ex_valid = 1'b0;
        tick();
        tick();
        n_chk++;
        if (if_clear !== 1'b0 || redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_end: got clr=%b rv=%b expected 0 0",
                     if_clear, redirect_valid);
        end
        id_valid = 1'b0;
        if_valid = 1'b1;
        if_pc    = 32'h40;
        ex_npc   = 32'h40;
        ex_valid = 1'b1;
        tick();
        n_chk++;
        if (redirect_valid !== 1'b0 || flush_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL if_pred_ok: got rv=%b fc=%0d expected 0 2",
                     redirect_valid, flush_cnt);
        end
        ex_npc = 32'h44;
        tick();
        n_chk++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44 ||
            flush_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL if_mispred: got rv=%b pc=%h fc=%0d expected 1 44 3",
                     redirect_valid, redirect_pc, flush_cnt);
        end
        rdy_in = 1'b0;
        tick();
        n_chk++;
        if (redirect_valid !== 1'b1 || flush_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL redir_hold: got rv=%b fc=%0d expected 1 3",
                     redirect_valid, flush_cnt);
        end
        ex_valid = 1'b0;
        rdy_in   = 1'b1;
        tick();
        n_chk++;
        if (redirect_valid !== 1'b0 || if_clear !== 1'b1 ||
            flush_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL resume: got rv=%b clr=%b fc=%0d expected 0 1 3",
                     redirect_valid, if_clear, flush_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        load_use(1'b1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_chk++;
            if (stall_if_id !== 1'b1 || err_tmo !== (i >= 4)) begin
                n_fail++;
                $display("FAIL tmo c%0d: got st=%b err=%b expected 1 %b",
                         i, stall_if_id, err_tmo, (i >= 4));
            end
        end
        load_use(1'b0);
        tick();
        n_chk++;
        if (err_tmo !== 1'b1 || stall_if_id !== 1'b0 ||
            stall_cnt !== 4'd6) begin
            n_fail++;
            $display("FAIL tmo_sticky: got err=%b st=%b cnt=%0d expected 1 0 6",
                     err_tmo, stall_if_id, stall_cnt);
        end
        load_use(1'b1);
        for (int i = 0; i < 11; i++) begin
            tick();
        end
        load_use(1'b0);
        tick();
        n_chk++;
        if (stall_cnt !== 4'd1 || err_tmo !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_wrap: got cnt=%0d err=%b expected 1 1",
                     stall_cnt, err_tmo);
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        load_use(1'b1);
        tick();
        tick();
        rdy_in = 1'b0;
        load_use(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (stall_if_id !== 1'b1 || bubble_id_ex !== 1'b1 ||
                stall_cnt !== 4'd2 || err_tmo !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze c%0d: got st=%b bb=%b cnt=%0d err=%b expected 1 1 2 0",
                         i, stall_if_id, bubble_id_ex, stall_cnt, err_tmo);
            end
        end
        rdy_in = 1'b1;
        tick();
        n_chk++;
        if (stall_if_id !== 1'b0 || stall_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL unfreeze: got st=%b cnt=%0d expected 0 2",
                     stall_if_id, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        id_valid = 1'b1;
        id_pc    = 32'h100;
        ex_npc   = 32'h180;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        n_chk++;
        if ({stall_if_id, bubble_id_ex, if_clear, id_clear,
             redirect_valid, err_tmo} !== 6'b0 ||
            redirect_pc !== 32'd0 || flush_cnt !== 4'd0 ||
            stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL async_rst: got clr=%b%b rv=%b pc=%h fc=%0d expected 00 0 0 0",
                     if_clear, id_clear, redirect_valid, redirect_pc,
                     flush_cnt);
        end
        tick();
        rst_in = 1'b1;
        tick();
        n_chk++;
        if (if_clear !== 1'b0 || redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: got clr=%b rv=%b expected 0 0",
                     if_clear, redirect_valid);
        end
    endtask

    initial begin
        idle();
        rst_in = 1'b0;
        test_reset();
        test_mem_hazard();
        test_load_use();
        test_x0();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_rdy_freeze();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
